// File: rtl/add32_seq_arbiter.sv
// Two-requester 32-bit add/subtract sequencer that time-shares one 16-bit CLA:
// round-robin accept, low halfword pass, high halfword pass, then hold the result.

module cla16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        C0,
  output logic [15:0] S,
  output logic        C16
);

  logic [15:0] g, p;
  logic [3:0]  gg, gp;
  logic [16:0] c;

  always_comb begin
    g  = A & B;
    p  = A ^ B;
    gg = '0;
    gp = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    // Group-level lookahead; bit carries then ripple only inside each nibble.
    c[0]  = C0;
    c[4]  = gg[0] | (gp[0] & C0);
    c[8]  = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & C0);
    c[12] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & C0);
    c[16] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]) |
            (gp[3] & gp[2] & gp[1] & gp[0] & C0);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    S   = p ^ c[15:0];
    C16 = c[16];
  end

endmodule

module add32_seq_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rq0_valid,
  output logic        rq0_ready,
  input  logic [31:0] rq0_a,
  input  logic [31:0] rq0_b,
  input  logic        rq0_sub,
  input  logic        rq1_valid,
  output logic        rq1_ready,
  input  logic [31:0] rq1_a,
  input  logic [31:0] rq1_b,
  input  logic        rq1_sub,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_sum,
  output logic        rsp_carry,
  output logic        rsp_ovf,
  output logic        rsp_zero
);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        cin_q, cin_d;
  logic        id_q, id_d;
  logic        ptr_q, ptr_d;
  logic [31:0] sum_q, sum_d;
  logic        carry_mid_q, carry_mid_d;
  logic        carry_q, carry_d;
  logic        ovf_q, ovf_d;

  logic        gnt_id, accept, op_sub;
  logic [31:0] op_a, op_b;
  logic [15:0] add_a, add_b, add_s;
  logic        add_c0, add_c16;

  always_comb begin
    // A lone requester wins outright; a tie goes to the pointer.
    gnt_id    = (rq0_valid && rq1_valid) ? ptr_q : rq1_valid;
    accept    = (state_q == StIdle) && (rq0_valid || rq1_valid) && !rst;
    rq0_ready = accept && !gnt_id;
    rq1_ready = accept && gnt_id;
    op_a      = gnt_id ? rq1_a   : rq0_a;
    op_b      = gnt_id ? rq1_b   : rq0_b;
    op_sub    = gnt_id ? rq1_sub : rq0_sub;
  end

  always_comb begin
    add_a  = (state_q == StHi) ? a_q[31:16]  : a_q[15:0];
    add_b  = (state_q == StHi) ? b_q[31:16]  : b_q[15:0];
    add_c0 = (state_q == StHi) ? carry_mid_q : cin_q;
  end

  cla16 u_cla (
    .A   (add_a),
    .B   (add_b),
    .C0  (add_c0),
    .S   (add_s),
    .C16 (add_c16)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    sum_d       = sum_q;
    carry_mid_d = carry_mid_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = op_a;
          b_d     = op_sub ? ~op_b : op_b;
          cin_d   = op_sub;
          id_d    = gnt_id;
          ptr_d   = ~gnt_id;
          state_d = StLo;
        end
      end
      StLo: begin
        sum_d[15:0] = add_s;
        carry_mid_d = add_c16;
        state_d     = StHi;
      end
      StHi: begin
        sum_d[31:16] = add_s;
        carry_d      = add_c16;
        ovf_d        = (a_q[31] == b_q[31]) && (add_s[15] != a_q[31]);
        state_d      = StDone;
      end
      StDone: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      id_q        <= 1'b0;
      ptr_q       <= 1'b0;
      sum_q       <= '0;
      carry_mid_q <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      sum_q       <= sum_d;
      carry_mid_q <= carry_mid_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
    end
  end

  assign rsp_valid = (state_q == StDone);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;
  assign rsp_ovf   = ovf_q;
  assign rsp_zero  = (sum_q == 32'd0);

endmodule

// File: tb/tb_add32_seq_arbiter.sv
// Directed bench for add32_seq_arbiter: arithmetic corner cases, latency,
// round-robin fairness, back-pressure and mid-operation reset.

module tb_add32_seq_arbiter;

  logic        clk, rst;
  logic        rq0_valid, rq0_ready, rq0_sub;
  logic [31:0] rq0_a, rq0_b;
  logic        rq1_valid, rq1_ready, rq1_sub;
  logic [31:0] rq1_a, rq1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_ovf, rsp_zero;
  logic [31:0] rsp_sum;

  int n_tests = 0;
  int n_fail  = 0;

  add32_seq_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .rq0_valid (rq0_valid),
    .rq0_ready (rq0_ready),
    .rq0_a     (rq0_a),
    .rq0_b     (rq0_b),
    .rq0_sub   (rq0_sub),
    .rq1_valid (rq1_valid),
    .rq1_ready (rq1_ready),
    .rq1_a     (rq1_a),
    .rq1_b     (rq1_b),
    .rq1_sub   (rq1_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_ovf   (rsp_ovf),
    .rsp_zero  (rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Single-requester operation with latency and result checks.
  task automatic op(input logic rq, input logic [31:0] a, input logic [31:0] b,
                    input logic sub, input logic [31:0] es, input logic ec,
                    input logic eo, input logic ez);
    @(negedge clk);
    rsp_ready = 1'b0;
    if (rq) begin
      rq1_valid = 1'b1; rq1_a = a; rq1_b = b; rq1_sub = sub;
    end else begin
      rq0_valid = 1'b1; rq0_a = a; rq0_b = b; rq0_sub = sub;
    end
    #1;
    chk("ready", rq ? rq1_ready : rq0_ready, 1);
    @(posedge clk);
    #1;
    rq0_valid = 1'b0;
    rq1_valid = 1'b0;
    @(negedge clk) chk("lat_lo", rsp_valid, 0);
    @(negedge clk) chk("lat_hi", rsp_valid, 0);
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_sum", rsp_sum, es);
    chk("rsp_carry", rsp_carry, ec);
    chk("rsp_ovf", rsp_ovf, eo);
    chk("rsp_zero", rsp_zero, ez);
    chk("rsp_id", rsp_id, rq);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    rq0_valid = 1'b1; rq0_a = '0; rq0_b = '0; rq0_sub = 1'b0;
    rq1_valid = 1'b0; rq1_a = '0; rq1_b = '0; rq1_sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", rq0_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_zero", rsp_zero, 1);
    chk("rst_id", rsp_id, 0);
    chk("rst_carry", rsp_carry, 0);
    chk("rst_ovf", rsp_ovf, 0);
    rst = 1'b0;
    rq0_valid = 1'b0;

    op(1'b0, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
    op(1'b1, 32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    op(1'b1, 32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    op(1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    op(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    op(1'b0, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);

    // Lone requester 1 is granted every fourth cycle.
    @(negedge clk);
    rsp_ready = 1'b1;
    rq1_valid = 1'b1; rq1_a = 32'd10; rq1_b = 32'd3; rq1_sub = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk("solo_rq1_ready", rq1_ready, (c % 4 == 0));
      chk("solo_rq0_ready", rq0_ready, 0);
    end
    rq1_valid = 1'b0;
    @(posedge clk);
    #1 rsp_ready = 1'b0;

    // Back-pressure: hold the result for five cycles with rq1 waiting.
    @(negedge clk);
    rq0_valid = 1'b1; rq0_a = 32'h12345678; rq0_b = 32'h11111111; rq0_sub = 1'b0;
    @(posedge clk);
    #1;
    rq0_valid = 1'b0;
    rq1_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_valid", rsp_valid, 1);
    chk("bp_sum", rsp_sum, 32'h23456789);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_sum", rsp_sum, 32'h23456789);
      chk("bp_hold_id", rsp_id, 0);
      chk("bp_rq0_ready", rq0_ready, 0);
      chk("bp_rq1_ready", rq1_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_valid", rsp_valid, 0);
    chk("bp_accept_rq1", rq1_ready, 1);
    @(posedge clk);
    #1 rq1_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_next_sum", rsp_sum, 32'd7);
    chk("bp_next_id", rsp_id, 1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;

    // Reset during HI: operation dropped and pointer back to requester 0.
    @(negedge clk);
    rq0_valid = 1'b1; rq0_a = 32'd1; rq0_b = 32'd2; rq0_sub = 1'b0;
    @(posedge clk);
    #1 rq0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_sum", rsp_sum, 0);
    @(posedge clk);

    // Both requesters continuously valid: grants alternate starting with 0.
    rsp_ready = 1'b1;
    rq0_a = 32'd10; rq0_b = 32'd3; rq0_sub = 1'b0;
    rq1_a = 32'd10; rq1_b = 32'd3; rq1_sub = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rq0_valid = 1'b1;
      rq1_valid = 1'b1;
      #1;
      chk("rr_rq0_ready", rq0_ready, (i % 2 == 0));
      chk("rr_rq1_ready", rq1_ready, (i % 2 == 1));
      repeat (3) @(negedge clk);
      chk("rr_valid", rsp_valid, 1);
      chk("rr_id", rsp_id, i % 2);
      chk("rr_sum", rsp_sum, (i % 2 == 0) ? 32'd13 : 32'd7);
    end
    rq0_valid = 1'b0;
    rq1_valid = 1'b0;
    @(posedge clk);
    #1 rsp_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
